// File: rtl/foos_pkg.sv
// Shared types and constants for the foosball score display: match states,
// winner codes, seven-segment patterns and BCD helpers.
package foos_pkg;

  localparam logic [0:0] PLAY = 1'b0;
  localparam logic [0:0] OVER = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_0     = 7'h40;
  localparam logic [6:0] SEG7_1     = 7'h79;
  localparam logic [6:0] SEG7_2     = 7'h24;
  localparam logic [6:0] SEG7_3     = 7'h30;
  localparam logic [6:0] SEG7_4     = 7'h19;
  localparam logic [6:0] SEG7_5     = 7'h12;
  localparam logic [6:0] SEG7_6     = 7'h02;
  localparam logic [6:0] SEG7_7     = 7'h78;
  localparam logic [6:0] SEG7_8     = 7'h00;
  localparam logic [6:0] SEG7_9     = 7'h10;
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG7_0;
      4'd1:    return SEG7_1;
      4'd2:    return SEG7_2;
      4'd3:    return SEG7_3;
      4'd4:    return SEG7_4;
      4'd5:    return SEG7_5;
      4'd6:    return SEG7_6;
      4'd7:    return SEG7_7;
      4'd8:    return SEG7_8;
      4'd9:    return SEG7_9;
      default: return SEG7_BLANK;
    endcase
  endfunction

  // Binary value of a two-digit BCD count, for comparison against a binary target
  function automatic logic [7:0] bcd2_value(input logic [7:0] bcd);
    return ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear; wraps 99 -> 00.
module bcd2_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'h00;
    end else if (clr) begin
      count <= 8'h00;
    end else if (inc) begin
      if (count[3:0] == 4'd9) begin
        count[3:0] <= 4'd0;
        count[7:4] <= (count[7:4] == 4'd9) ? 4'd0 : count[7:4] + 4'd1;
      end else begin
        count[3:0] <= count[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_board.sv
// Match scorekeeper: edge-detects goal levels, keeps per-player BCD scores,
// detects the winner and drives the multiplexed 4-digit seven-segment display.
module score_board
  import foos_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       score1_in,
  input  logic       score2_in,
  input  logic       new_game,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic          prev1, prev2;
  logic          goal1, goal2;
  logic          inc1, inc2;
  logic          win1, win2;
  logic [7:0]    count1, count2;
  logic [0:0]    state;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [3:0]    digit;
  logic [3:0]    an_next;

  assign goal1 = score1_in & ~prev1;
  assign goal2 = score2_in & ~prev2;

  // new_game takes priority: a goal landing on the same edge is discarded
  assign inc1 = goal1 & (state == PLAY) & ~new_game;
  assign inc2 = goal2 & (state == PLAY) & ~new_game;

  assign win1 = inc1 && (WIN_SCORE != 0) &&
                ((bcd2_value(count1) + 8'd1) == 8'(WIN_SCORE));
  assign win2 = inc2 && (WIN_SCORE != 0) &&
                ((bcd2_value(count2) + 8'd1) == 8'(WIN_SCORE));

  bcd2_counter u_count1 (
    .clk   (clk),
    .reset (reset),
    .clr   (new_game),
    .inc   (inc1),
    .count (count1)
  );

  bcd2_counter u_count2 (
    .clk   (clk),
    .reset (reset),
    .clr   (new_game),
    .inc   (inc2),
    .count (count2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev1  <= 1'b0;
      prev2  <= 1'b0;
      state  <= PLAY;
      winner <= WIN_NONE;
    end else begin
      prev1 <= score1_in;
      prev2 <= score2_in;
      if (new_game) begin
        state  <= PLAY;
        winner <= WIN_NONE;
      end else if (win1 || win2) begin
        state  <= OVER;
        winner <= {win2, win1};
      end
    end
  end

  assign game_over = (state == OVER);
  assign dp        = 1'b1;

  // Blink starts in the dark half so the winner's digits flash off right away
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (new_game) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (state == PLAY) begin
      blink_cnt <= '0;
      phase     <= ~(win1 | win2);
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_comb begin
    digit   = count2[3:0];
    an_next = 4'b1110;
    case (idx)
      2'd0: begin digit = count2[3:0]; an_next = 4'b1110; end
      2'd1: begin digit = count2[7:4]; an_next = 4'b1101; end
      2'd2: begin digit = count1[3:0]; an_next = 4'b1011; end
      default: begin digit = count1[7:4]; an_next = 4'b0111; end
    endcase
    if (!phase) begin
      case (winner)
        WIN_P1:   an_next = an_next | 4'b1100;
        WIN_P2:   an_next = an_next | 4'b0011;
        WIN_DRAW: an_next = 4'b1111;
        default:  an_next = an_next;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1110;
      seg <= SEG7_0;
    end else begin
      an  <= an_next;
      seg <= seg7(digit);
    end
  end

endmodule

// File: tb/tb_score_board.sv
// Bench for score_board: two instances (WIN_SCORE=3 and WIN_SCORE=0) share stimulus;
// a per-cycle reference model plus directed literal expectations.
module tb_score_board;

  localparam int REFRESH = 4;
  localparam int BLINK   = 8;

  logic       clk = 1'b0;
  logic       reset, score1_in, score2_in, new_game;
  logic       game_over_a, game_over_b;
  logic [1:0] winner_a, winner_b;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  score_board #(.WIN_SCORE(3), .REFRESH_DIV(REFRESH), .BLINK_DIV(BLINK)) dut_a (
    .clk(clk), .reset(reset), .score1_in(score1_in), .score2_in(score2_in),
    .new_game(new_game), .game_over(game_over_a), .winner(winner_a),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  score_board #(.WIN_SCORE(0), .REFRESH_DIV(REFRESH), .BLINK_DIV(BLINK)) dut_b (
    .clk(clk), .reset(reset), .score1_in(score1_in), .score2_in(score2_in),
    .new_game(new_game), .game_over(game_over_b), .winner(winner_b),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] an_tab [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference model state: scores as plain integers, cycles since reset/OVER entry
  int         win_score [2] = '{3, 0};
  int         m_c1 [2];
  int         m_c2 [2];
  int         m_over_cycles [2];
  bit         m_over [2];
  logic [1:0] m_winner [2];
  bit         m_p1, m_p2;
  int         m_ticks;
  logic [3:0] exp_an [2];
  logic [6:0] exp_seg [2];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  function automatic logic [3:0] model_an(input int i);
    int pos = (m_ticks / REFRESH) % 4;
    logic [3:0] a = ~(4'b0001 << pos);
    if (m_over[i] && ((m_over_cycles[i] / BLINK) % 2 == 0)) begin
      if (m_winner[i][0]) a[3:2] = 2'b11;
      if (m_winner[i][1]) a[1:0] = 2'b11;
    end
    return a;
  endfunction

  function automatic logic [6:0] model_seg(input int i);
    int pos = (m_ticks / REFRESH) % 4;
    int v = (pos < 2) ? m_c2[i] : m_c1[i];
    return seg_tab[(pos % 2 == 0) ? (v % 10) : (v / 10)];
  endfunction

  always @(posedge clk) begin
    bit g1, g2, w1, w2;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_c1[i] = 0; m_c2[i] = 0; m_over[i] = 0; m_winner[i] = 2'b00;
        m_over_cycles[i] = 0; exp_an[i] = 4'b1110; exp_seg[i] = 7'h40;
      end
      m_p1 = 0; m_p2 = 0; m_ticks = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_an[i]  = model_an(i);
        exp_seg[i] = model_seg(i);
      end
      g1 = score1_in && !m_p1;
      g2 = score2_in && !m_p2;
      for (int i = 0; i < 2; i++) begin
        if (new_game) begin
          m_c1[i] = 0; m_c2[i] = 0; m_over[i] = 0; m_winner[i] = 2'b00;
          m_over_cycles[i] = 0;
        end else if (!m_over[i]) begin
          if (g1) m_c1[i] = (m_c1[i] + 1) % 100;
          if (g2) m_c2[i] = (m_c2[i] + 1) % 100;
          w1 = g1 && (win_score[i] != 0) && (m_c1[i] == win_score[i]);
          w2 = g2 && (win_score[i] != 0) && (m_c2[i] == win_score[i]);
          if (w1 || w2) begin
            m_over[i] = 1; m_winner[i] = {w2, w1}; m_over_cycles[i] = 0;
          end
        end else begin
          m_over_cycles[i]++;
        end
      end
      m_p1 = score1_in; m_p2 = score2_in; m_ticks++;
    end
    #1;
    check("a.game_over", game_over_a, m_over[0]);
    check("a.winner",    winner_a,    m_winner[0]);
    check("a.an",        an_a,        exp_an[0]);
    check("a.seg",       seg_a,       exp_seg[0]);
    check("a.dp",        dp_a,        1'b1);
    check("b.game_over", game_over_b, m_over[1]);
    check("b.winner",    winner_b,    m_winner[1]);
    check("b.an",        an_b,        exp_an[1]);
    check("b.seg",       seg_b,       exp_seg[1]);
    check("b.dp",        dp_b,        1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goal(input bit a, input bit b);
    score1_in = a; score2_in = b;
    @(negedge clk);
    score1_in = 0; score2_in = 0;
    @(negedge clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1;
    @(negedge clk);
    new_game = 0;
  endtask

  task automatic wait_an(input int which, input logic [3:0] target);
    int n = 0;
    while (((which == 0) ? an_a : an_b) !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      compared++;
      mismatched++;
      $display("FAIL wait_an inst %0d: got %b want %b within 40 cycles", which,
               (which == 0) ? an_a : an_b, target);
    end
  endtask

  initial begin
    reset = 1; score1_in = 0; score2_in = 0; new_game = 0;
    cyc(3);
    check("rst.an", an_a, 4'b1110);
    check("rst.seg", seg_a, 7'h40);
    check("rst.game_over", game_over_a, 1'b0);
    check("rst.winner", winner_a, 2'b00);
    reset = 0;

    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("idle.an", an_a, an_tab[(k - 1) / 4]);
      check("idle.seg", seg_a, 7'h40);
    end

    // Long goal level counts once
    score1_in = 1;
    cyc(5);
    score1_in = 0;
    wait_an(0, 4'b1011); check("p1.ones", seg_a, 7'h79);
    wait_an(0, 4'b0111); check("p1.tens", seg_a, 7'h40);
    wait_an(0, 4'b1110); check("p2.ones", seg_a, 7'h40);
    wait_an(0, 4'b1101); check("p2.tens", seg_a, 7'h40);

    pulse_new_game();
    goal(1, 1);
    wait_an(0, 4'b1011); check("sim.p1", seg_a, 7'h79);
    wait_an(0, 4'b1110); check("sim.p2", seg_a, 7'h79);

    // P2 wins 0:3; later P1 goal is ignored
    pulse_new_game();
    goal(0, 1); goal(0, 1); goal(0, 1);
    check("p2win.game_over", game_over_a, 1'b1);
    check("p2win.winner", winner_a, 2'b10);
    goal(1, 0);
    wait_an(0, 4'b1011); check("over.p1frozen", seg_a, 7'h40);
    cyc(32);
    check("over.still", game_over_a, 1'b1);

    // Draw at 3:3
    pulse_new_game();
    goal(1, 1); goal(1, 1);
    score1_in = 1; score2_in = 1;
    @(negedge clk);
    score1_in = 0; score2_in = 0;
    check("draw.winner", winner_a, 2'b11);
    check("draw.game_over", game_over_a, 1'b1);
    @(negedge clk);
    check("draw.an_dark", an_a, 4'b1111);
    cyc(20);
    pulse_new_game();
    check("ng.game_over", game_over_a, 1'b0);
    check("ng.winner", winner_a, 2'b00);
    cyc(4);

    // Wrap on the no-win instance
    pulse_new_game();
    for (int g = 0; g < 99; g++) goal(1, 0);
    wait_an(1, 4'b0111); check("b99.tens", seg_b, 7'h10);
    wait_an(1, 4'b1011); check("b99.ones", seg_b, 7'h10);
    check("b99.game_over", game_over_b, 1'b0);
    goal(1, 0);
    wait_an(1, 4'b1011); check("b00.ones", seg_b, 7'h40);
    wait_an(1, 4'b0111); check("b00.tens", seg_b, 7'h40);
    check("b00.game_over", game_over_b, 1'b0);
    check("b00.winner", winner_b, 2'b00);
    check("a.p1win", winner_a, 2'b01);

    goal(1, 0); goal(1, 0); goal(1, 0);
    score1_in = 1;
    @(negedge clk);
    reset = 1;
    #1;
    check("arst.an_b", an_b, 4'b1110);
    check("arst.seg_b", seg_b, 7'h40);
    check("arst.an_a", an_a, 4'b1110);
    check("arst.game_over_a", game_over_a, 1'b0);
    check("arst.winner_a", winner_a, 2'b00);
    score1_in = 0;
    cyc(2);
    reset = 0;
    cyc(20);
    goal(0, 1);
    wait_an(1, 4'b1110); check("post.p2", seg_b, 7'h79);
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
